// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer.
// Streams sequential instruction fetches from a ROM into a small FIFO of
// {pc, inst} entries. Requests are credit-limited so the FIFO can never
// overflow. A redirect flushes the buffer, drops any outstanding response
// and restarts fetching at a new address.
module inst_prefetch_buffer #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 4,
    parameter int                    ROM_LATENCY = 1,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    PC_STEP     = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic                        rom_chip_enable,
    output logic [ADDR_WIDTH-1:0]       rom_address_output,
    input  logic [DATA_WIDTH-1:0]       rom_data_input,
    output logic                        fetch_valid,
    output logic [DATA_WIDTH-1:0]       fetch_inst,
    output logic [ADDR_WIDTH-1:0]       fetch_pc,
    input  logic                        fetch_ready,
    input  logic                        redirect,
    input  logic [ADDR_WIDTH-1:0]       redirect_pc,
    output logic [$clog2(DEPTH):0]      occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Fetch address state
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [ADDR_WIDTH-1:0] last_addr;

    // FIFO storage and control
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      occ_q;

    // Values shown on the fetch port while the buffer is empty
    logic [ADDR_WIDTH-1:0] hold_pc;
    logic [DATA_WIDTH-1:0] hold_inst;

    // Handshake terms
    logic                  inflight;
    logic [CNT_W-1:0]      in_use;
    logic                  issue;
    logic                  push_en;
    logic [ADDR_WIDTH-1:0] push_pc;
    logic                  head_vld;
    logic                  pop_en;

    // Credit check: only current occupancy plus outstanding request count;
    // a pop in this cycle does not make room until the next one.
    always_comb begin
        in_use   = occ_q + CNT_W'(inflight);
        issue    = !reset && !redirect && (in_use < CNT_W'(DEPTH));
        head_vld = (occ_q != '0);
        pop_en   = head_vld && fetch_ready && !redirect && !reset;
    end

    // ROM request port; address holds the last issued value when idle
    always_comb begin
        rom_chip_enable = issue;
        if (reset) begin
            rom_address_output = '0;
        end else if (issue) begin
            rom_address_output = next_pc;
        end else begin
            rom_address_output = last_addr;
        end
    end

    // Fetch port: head entry when valid, otherwise the last value shown
    always_comb begin
        fetch_valid = !reset && head_vld;
        if (reset) begin
            fetch_inst = '0;
            fetch_pc   = '0;
        end else if (head_vld) begin
            fetch_inst = inst_mem[rd_ptr];
            fetch_pc   = pc_mem[rd_ptr];
        end else begin
            fetch_inst = hold_inst;
            fetch_pc   = hold_pc;
        end
    end

    assign occupancy = occ_q;

    generate
        if (ROM_LATENCY == 0) begin : g_lat0
            // Response arrives in the issue cycle itself
            assign inflight = 1'b0;
            assign push_en  = issue;
            assign push_pc  = next_pc;
        end else begin : g_lat1
            logic                  vld_p1;
            logic [ADDR_WIDTH-1:0] pc_p1;

            // Issue -> response stage boundary: remember the outstanding request
            always_ff @(posedge clock) begin
                if (reset) begin
                    vld_p1 <= 1'b0;
                end else begin
                    vld_p1 <= issue;
                end
                pc_p1 <= next_pc;
            end

            // A redirect in the response cycle discards the stale word
            assign inflight = vld_p1;
            assign push_en  = vld_p1 && !redirect && !reset;
            assign push_pc  = pc_p1;
        end
    endgenerate

    // Next-fetch PC: reset, then redirect, then advance on each issue
    always_ff @(posedge clock) begin
        if (reset) begin
            next_pc   <= RESET_PC;
            last_addr <= '0;
        end else if (redirect) begin
            next_pc   <= redirect_pc;
        end else if (issue) begin
            last_addr <= next_pc;
            next_pc   <= next_pc + ADDR_WIDTH'(PC_STEP);
        end
    end

    // FIFO pointers and occupancy; redirect flushes everything
    always_ff @(posedge clock) begin
        if (reset || redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   occ_q <= occ_q + CNT_W'(1);
                2'b01:   occ_q <= occ_q - CNT_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // FIFO entry write
    always_ff @(posedge clock) begin
        if (push_en) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= rom_data_input;
        end
    end

    // Remember the head shown on the fetch port so it persists when empty
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_pc   <= '0;
            hold_inst <= '0;
        end else if (head_vld) begin
            hold_pc   <= pc_mem[rd_ptr];
            hold_inst <= inst_mem[rd_ptr];
        end
    end

endmodule
